// File: rtl/decode_pkg.sv
// Shared constants, field positions, FSM state and control-word layout for the
// instruction decode / register-read stage.
package decode_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int IMM_WIDTH   = 16;
  localparam int REG_COUNT   = 8;
  localparam int ADDR_WIDTH  = $clog2(REG_COUNT);
  localparam int INSTR_WIDTH = 32;

  localparam logic [2:0] OP_SHIFT_REG   = 3'b000;
  localparam logic [2:0] OP_ARITH_LOGIC = 3'b001;
  localparam logic [2:0] OP_MEM_WRITE   = 3'b100;
  localparam logic [2:0] OP_MEM_READ    = 3'b101;

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_AND = 3'b100;
  localparam logic [2:0] SEL_OR  = 3'b101;
  localparam logic [2:0] SEL_XOR = 3'b110;

  localparam int OP_LSB      = 29;
  localparam int SEL_LSB     = 26;
  localparam int IMM_SEL_BIT = 25;
  localparam int RD_LSB      = 22;
  localparam int RS1_LSB     = 19;
  localparam int RS2_LSB     = 16;
  localparam int IMM_LSB     = 0;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_e;

  typedef struct packed {
    logic [2:0] op_type;
    logic [2:0] opselect;
    logic       imm_sel;
  } ctrl_t;

  // Logical ops take their immediate as an unsigned mask; everything else sign-extends.
  function automatic logic [DATA_WIDTH-1:0] extend_imm(logic [2:0] op_type,
                                                       logic [2:0] opselect,
                                                       logic [IMM_WIDTH-1:0] imm16);
    logic zero_ext;
    zero_ext = (op_type == OP_ARITH_LOGIC) &&
               (opselect == SEL_AND || opselect == SEL_OR || opselect == SEL_XOR);
    if (zero_ext) return {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, imm16};
    return {{(DATA_WIDTH-IMM_WIDTH){imm16[IMM_WIDTH-1]}}, imm16};
  endfunction

  function automatic logic uses_rs2(logic [2:0] op_type, logic imm_sel);
    return !imm_sel || (op_type == OP_MEM_WRITE);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bus between the instruction source / writeback path and the decode stage,
// including the registered issue outputs that feed execute.
interface decode_stage_if;
  import decode_pkg::*;

  // instr is transferred on a cycle where instr_valid and instr_ready are both 1;
  // the source holds instr stable while instr_valid=1 and instr_ready=0, and
  // instr_ready never depends on instr_valid.
  logic [INSTR_WIDTH-1:0] instr;
  logic                   instr_valid;
  logic                   instr_ready;
  logic                   stall_in;
  logic                   wb_en;
  logic [ADDR_WIDTH-1:0]  wb_addr;
  logic [DATA_WIDTH-1:0]  wb_data;
  logic [DATA_WIDTH-1:0]  src1;
  logic [DATA_WIDTH-1:0]  src2;
  logic [DATA_WIDTH-1:0]  imm;
  ctrl_t                  control_in;
  logic                   enable_ex;
  logic [ADDR_WIDTH-1:0]  dest_out;

  modport master (
    output instr, instr_valid, stall_in, wb_en, wb_addr, wb_data,
    input  instr_ready, src1, src2, imm, control_in, enable_ex, dest_out
  );

  modport slave (
    input  instr, instr_valid, stall_in, wb_en, wb_addr, wb_data,
    output instr_ready, src1, src2, imm, control_in, enable_ex, dest_out
  );

endinterface

// File: rtl/decode_stage_reg_file.sv
// 8x32 architectural register file: two combinational read ports with
// writeback bypass, one synchronous write port, r0 hardwired to zero.
module reg_file
  import decode_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b
);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wr_en && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (rd_addr_a == '0)                        rd_data_a = '0;
    else if (wr_en && wr_addr == rd_addr_a)     rd_data_a = wr_data;
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (rd_addr_b == '0)                        rd_data_b = '0;
    else if (wr_en && wr_addr == rd_addr_b)     rd_data_b = wr_data;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode / register-read stage: decodes one instruction per handshake, reads
// operands and registers the execute-stage control word, with a one-cycle
// bubble for load-use hazards.
module decode_stage
  import decode_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  decode_stage_if.slave  bus,
  output state_e         state_dbg
);

  logic [2:0]            op_type;
  logic [2:0]            opselect;
  logic                  imm_sel;
  logic [ADDR_WIDTH-1:0] rd;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic [IMM_WIDTH-1:0]  imm16;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic                  load_pending;
  logic                  hazard;
  logic                  fire;
  state_e                state;
  state_e                state_next;

  assign op_type  = bus.instr[OP_LSB +: 3];
  assign opselect = bus.instr[SEL_LSB +: 3];
  assign imm_sel  = bus.instr[IMM_SEL_BIT];
  assign rd       = bus.instr[RD_LSB +: ADDR_WIDTH];
  assign rs1      = bus.instr[RS1_LSB +: ADDR_WIDTH];
  assign rs2      = bus.instr[RS2_LSB +: ADDR_WIDTH];
  assign imm16    = bus.instr[IMM_LSB +: IMM_WIDTH];

  reg_file u_reg_file (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (bus.wb_en),
    .wr_addr   (bus.wb_addr),
    .wr_data   (bus.wb_data),
    .rd_addr_a (rs1),
    .rd_data_a (rs1_data),
    .rd_addr_b (rs2),
    .rd_data_b (rs2_data)
  );

  // The load currently sitting in execute has no data yet for its destination.
  assign load_pending = bus.enable_ex && (bus.control_in.op_type == OP_MEM_READ) &&
                        (bus.dest_out != '0);
  assign hazard = load_pending &&
                  ((bus.dest_out == rs1) ||
                   (uses_rs2(op_type, imm_sel) && bus.dest_out == rs2));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (!bus.stall_in && hazard && bus.instr_valid) state_next = BUBBLE;
      BUBBLE:  if (!bus.stall_in) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    bus.instr_ready = reset && (state == RUN) && !bus.stall_in && !hazard;
    fire            = bus.instr_valid && bus.instr_ready;
  end

  assign state_dbg = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.src1       <= '0;
      bus.src2       <= '0;
      bus.imm        <= '0;
      bus.control_in <= '0;
      bus.enable_ex  <= 1'b0;
      bus.dest_out   <= '0;
    end else if (!bus.stall_in) begin
      bus.enable_ex <= fire;
      if (fire) begin
        bus.src1       <= rs1_data;
        bus.src2       <= rs2_data;
        bus.imm        <= extend_imm(op_type, opselect, imm16);
        bus.control_in <= ctrl_t'{op_type, opselect, imm_sel};
        bus.dest_out   <= rd;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios with literal
// expectations plus randomized traffic checked cycle-by-cycle against a model.
module tb_decode_stage;
  import decode_pkg::*;

  localparam int TW = 3*DATA_WIDTH + 7 + ADDR_WIDTH;

  logic   clk = 1'b0;
  logic   rst_n;
  state_e state_dbg;
  int     checks = 0;
  int     errors = 0;

  decode_stage_if bus();

  decode_stage dut (
    .clock     (clk),
    .reset     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helpers ----------------
  task automatic tally(input string name, input bit ok, input string got_s, input string exp_s);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s, expected %s", name, got_s, exp_s);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    tally(name, got === exp, $sformatf("0x%h", got), $sformatf("0x%h", exp));
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    tally(name, got === exp, $sformatf("%b", got), $sformatf("%b", exp));
  endtask

  task automatic checkt(input string name, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    tally(name, got === exp, $sformatf("0x%h", got), $sformatf("0x%h", exp));
  endtask

  // ---------------- reference model ----------------
  logic [DATA_WIDTH-1:0] m_regs [REG_COUNT];
  logic [DATA_WIDTH-1:0] m_src1, m_src2, m_imm;
  logic [6:0]            m_ctrl;
  logic [2:0]            m_dest;
  logic                  m_en, m_bubble;
  logic [TW-1:0]         exp_q[$];
  logic                  prev_rst = 1'b0;
  logic                  prev_stall = 1'b0;

  function automatic logic [31:0] model_imm(logic [2:0] op, logic [2:0] sel, logic [15:0] i16);
    int v;
    v = int'(i16);
    if (!(op == 3'd1 && sel >= 3'd4 && sel <= 3'd6) && v >= 32768) v = v - 65536;
    return 32'(v);
  endfunction

  function automatic logic [31:0] operand(logic [2:0] a);
    if (a == 3'd0) return 32'd0;
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < REG_COUNT; i++) m_regs[i] = '0;
    m_src1 = '0; m_src2 = '0; m_imm = '0; m_ctrl = '0; m_dest = '0;
    m_en = 1'b0; m_bubble = 1'b0;
    exp_q.delete();
  endtask

  initial model_reset();

  // ---------------- compare process ----------------
  always @(negedge clk) begin : compare_proc
    logic [TW-1:0] got_t, exp_t;
    logic [2:0]    op, sel, rd, rs1, rs2;
    logic          isel, use2, hazard, m_ready, fire;
    got_t = {bus.src1, bus.src2, bus.imm, bus.control_in, bus.dest_out};
    if (!rst_n) begin
      model_reset();
      check1("reset_ready", bus.instr_ready, 1'b0);
      check1("reset_enable_ex", bus.enable_ex, 1'b0);
      checkt("reset_outputs", got_t, '0);
      prev_rst = 1'b0;
    end else begin
      if (bus.enable_ex && prev_rst && !prev_stall) begin
        if (exp_q.size() == 0) tally("issue_unexpected", 1'b0, "issue", "none");
        else begin
          exp_t = exp_q.pop_front();
          checkt("issue_tuple", got_t, exp_t);
        end
      end
      check1("enable_ex", bus.enable_ex, m_en);
      checkt("outputs", got_t, {m_src1, m_src2, m_imm, m_ctrl, m_dest});

      op = bus.instr[31:29]; sel = bus.instr[28:26]; isel = bus.instr[25];
      rd = bus.instr[24:22]; rs1 = bus.instr[21:19]; rs2 = bus.instr[18:16];
      use2   = !isel || op == 3'b100;
      // a load now in execute blocks any reader of its destination for one turn
      hazard = m_en && m_ctrl[6:4] == 3'b101 && m_dest != 3'd0 &&
               (m_dest == rs1 || (use2 && m_dest == rs2));
      m_ready = !m_bubble && !bus.stall_in && !hazard;
      check1("instr_ready", bus.instr_ready, m_ready);
      fire = bus.instr_valid && m_ready;

      if (!bus.stall_in) begin
        if (fire) begin
          m_src1 = operand(rs1);
          m_src2 = operand(rs2);
          m_imm  = model_imm(op, sel, bus.instr[15:0]);
          m_ctrl = {op, sel, isel};
          m_dest = rd;
          exp_q.push_back({m_src1, m_src2, m_imm, m_ctrl, m_dest});
        end
        m_en     = fire;
        m_bubble = !m_bubble && hazard && bus.instr_valid;
      end
      if (bus.wb_en && bus.wb_addr != 3'd0) m_regs[bus.wb_addr] = bus.wb_data;
      prev_rst   = 1'b1;
      prev_stall = bus.stall_in;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] mk(logic [2:0] op, logic [2:0] sel, logic isel, logic [2:0] rd,
                                     logic [2:0] rs1, logic [2:0] rs2, logic [15:0] i16);
    return {op, sel, isel, rd, rs1, rs2, i16};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [2:0] op;
    case ($urandom_range(0, 3))
      0:       op = 3'b000;
      1:       op = 3'b001;
      2:       op = 3'b100;
      default: op = 3'b101;
    endcase
    return mk(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
              3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 16'($urandom));
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wb(input logic [2:0] addr, input logic [31:0] data);
    bus.wb_en = 1'b1; bus.wb_addr = addr; bus.wb_data = data;
    cyc();
    bus.wb_en = 1'b0;
  endtask

  task automatic send(input logic [31:0] word, output int waited);
    bus.instr = word; bus.instr_valid = 1'b1; waited = 0;
    while (1) begin
      @(negedge clk);
      if (bus.instr_ready) break;
      waited++;
      if (waited > 50) begin
        tally("send_timeout", 1'b0, "no ready", "ready");
        break;
      end
    end
    cyc();
    bus.instr_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int  w;
    logic acc;
    bus.instr = '0; bus.instr_valid = 1'b0; bus.stall_in = 1'b0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check1("rst_enable_ex", bus.enable_ex, 1'b0);
    check32("rst_src1", bus.src1, 32'd0);
    check32("rst_src2", bus.src2, 32'd0);
    check32("rst_imm", bus.imm, 32'd0);
    check32("rst_control", 32'(bus.control_in), 32'd0);
    check1("rst_ready", bus.instr_ready, 1'b1);
    check1("rst_state", state_dbg, RUN);

    wb(3'd1, 32'd5);
    wb(3'd2, 32'd7);
    send(mk(3'b001, 3'b000, 1'b0, 3'd3, 3'd1, 3'd2, 16'h0000), w);
    check32("add_src1", bus.src1, 32'd5);
    check32("add_src2", bus.src2, 32'd7);
    check32("add_control", 32'(bus.control_in), 32'h10);
    check1("add_enable_ex", bus.enable_ex, 1'b1);
    check32("add_dest", 32'(bus.dest_out), 32'd3);

    send(mk(3'b001, 3'b000, 1'b1, 3'd3, 3'd1, 3'd2, 16'hFFF0), w);
    check32("imm_sext", bus.imm, 32'hFFFFFFF0);
    send(mk(3'b001, 3'b100, 1'b1, 3'd3, 3'd1, 3'd2, 16'hFFF0), w);
    check32("imm_zext_and", bus.imm, 32'h0000FFF0);
    send(mk(3'b100, 3'b110, 1'b1, 3'd3, 3'd1, 3'd2, 16'h8001), w);
    check32("imm_sext_store", bus.imm, 32'hFFFF8001);

    // load-use: ready is low for the hazard cycle and the bubble cycle
    send(mk(3'b101, 3'b000, 1'b1, 3'd4, 3'd1, 3'd0, 16'h0010), w);
    send(mk(3'b001, 3'b000, 1'b0, 3'd5, 3'd4, 3'd2, 16'h0000), w);
    check32("load_use_wait", 32'(w), 32'd2);
    check32("load_use_dest", 32'(bus.dest_out), 32'd5);
    check32("load_use_src2", bus.src2, 32'd7);
    send(mk(3'b101, 3'b000, 1'b1, 3'd0, 3'd1, 3'd0, 16'h0010), w);
    send(mk(3'b001, 3'b000, 1'b0, 3'd5, 3'd0, 3'd2, 16'h0000), w);
    check32("load_r0_no_bubble", 32'(w), 32'd0);
    send(mk(3'b101, 3'b000, 1'b1, 3'd2, 3'd1, 3'd0, 16'h0000), w);
    send(mk(3'b001, 3'b000, 1'b0, 3'd6, 3'd1, 3'd2, 16'h0000), w);
    check32("load_use_rs2_wait", 32'(w), 32'd2);
    send(mk(3'b101, 3'b000, 1'b1, 3'd2, 3'd1, 3'd0, 16'h0000), w);
    send(mk(3'b001, 3'b000, 1'b1, 3'd6, 3'd1, 3'd2, 16'h0004), w);
    check32("rs2_unused_no_bubble", 32'(w), 32'd0);

    // stall freezes everything, then the held instruction issues exactly once
    send(mk(3'b001, 3'b000, 1'b0, 3'd6, 3'd1, 3'd2, 16'h0000), w);
    bus.instr = mk(3'b001, 3'b001, 1'b0, 3'd7, 3'd2, 3'd1, 16'h0000);
    bus.instr_valid = 1'b1;
    bus.stall_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check1("stall_ready", bus.instr_ready, 1'b0);
      check1("stall_enable_ex", bus.enable_ex, 1'b1);
      check32("stall_src1", bus.src1, 32'd5);
      check32("stall_dest", 32'(bus.dest_out), 32'd6);
      cyc();
    end
    bus.stall_in = 1'b0;
    send(bus.instr, w);
    check32("after_stall_wait", 32'(w), 32'd0);
    check32("after_stall_src1", bus.src1, 32'd7);
    check32("after_stall_dest", 32'(bus.dest_out), 32'd7);
    cyc();
    check1("after_stall_drain", bus.enable_ex, 1'b0);

    bus.wb_en = 1'b1; bus.wb_addr = 3'd5; bus.wb_data = 32'hDEADBEEF;
    send(mk(3'b001, 3'b000, 1'b0, 3'd1, 3'd5, 3'd0, 16'h0000), w);
    bus.wb_en = 1'b0;
    check32("bypass_src1", bus.src1, 32'hDEADBEEF);
    check32("bypass_src2_r0", bus.src2, 32'd0);

    // reset asserted while in BUBBLE
    send(mk(3'b101, 3'b000, 1'b1, 3'd2, 3'd0, 3'd0, 16'h0000), w);
    bus.instr = mk(3'b001, 3'b000, 1'b0, 3'd3, 3'd2, 3'd0, 16'h0000);
    bus.instr_valid = 1'b1;
    cyc();
    check1("bubble_state", state_dbg, BUBBLE);
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    #1;
    check1("bubble_rst_enable_ex", bus.enable_ex, 1'b0);
    check32("bubble_rst_src1", bus.src1, 32'd0);
    check32("bubble_rst_control", 32'(bus.control_in), 32'd0);
    check1("bubble_rst_ready", bus.instr_ready, 1'b0);
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    check1("bubble_rst_state", state_dbg, RUN);
    check1("bubble_rst_ready_after", bus.instr_ready, 1'b1);

    // randomized traffic; an offered instruction is held until it is taken
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      acc = bus.instr_valid && bus.instr_ready;
      cyc();
      if (!bus.instr_valid || acc) begin
        bus.instr_valid = ($urandom_range(0, 3) != 0);
        bus.instr = rand_instr();
      end
      bus.stall_in = ($urandom_range(0, 9) == 0);
      bus.wb_en    = 1'($urandom_range(0, 1));
      bus.wb_addr  = 3'($urandom_range(0, 7));
      bus.wb_data  = $urandom;
    end
    bus.instr_valid = 1'b0; bus.stall_in = 1'b0; bus.wb_en = 1'b0;
    repeat (4) cyc();
    check32("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction decode and register-read stage directly upstream of the execute stage (top_dut).
- Accepts 32-bit instructions over a valid/ready handshake, reads an internal register file, and builds the execute-stage control word and immediate.
- Drives registered src1/src2/imm/control_in/enable_ex into execute.
- Accepts register writeback from downstream and inserts a one-cycle bubble on load-use hazards.

Parameters:
DATA_WIDTH, 32, register/operand width
IMM_WIDTH, 16, instruction immediate field width
REG_COUNT, 8, architectural registers; address width = clog2(REG_COUNT) = 3

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
instr  input  32  instruction word
instr_valid  input  1  instr is valid this cycle
instr_ready  output  1  stage accepts instr this cycle
stall_in  input  1  downstream hold; freeze all outputs
wb_en  input  1  register write enable
wb_addr  input  3  write register address
wb_data  input  32  write data
src1  output  32  operand 1 to execute (registered)
src2  output  32  operand 2 / store data to execute (registered)
imm  output  32  extended immediate (registered)
control_in  output  7  {op_type[2:0], opselect[2:0], imm_sel} (registered)
enable_ex  output  1  execute stage holds a valid instruction (registered)
dest_out  output  3  destination register of issued instruction (registered)

Behaviour:
- Instruction fields: [31:29] op_type (SHIFT_REG 000, ARITH_LOGIC 001, MEM_WRITE 100, MEM_READ 101); [28:26] opselect; [25] imm_sel; [24:22] rd; [21:19] rs1; [18:16] rs2; [15:0] imm16.
- Reset (reset=0, asynchronous): src1, src2, imm, control_in, dest_out = 0; enable_ex = 0; state = RUN; all registers = 0. instr_ready = 0 while in reset.
- Register file: 8x32. r0 always reads 0; writes to r0 are ignored.
  - Write occurs on the clock edge when wb_en=1.
  - A read of wb_addr in the same cycle returns wb_data (write-through bypass), except for r0.
- Immediate: imm16 is sign-extended to 32 bits. Exception: op_type ARITH_LOGIC with opselect AND/OR/XOR (100/101/110) zero-extends.
- rs2 is used when imm_sel=0 or op_type=MEM_WRITE. rs1 is always used.
- Hazard: last issued instruction had op_type MEM_READ, enable_ex=1, dest_out != 0, and dest_out equals rs1 (or rs2 when used).
- Issue (fire = instr_valid & instr_ready): next edge loads decoded fields into the output registers with enable_ex=1. Latency is 1 cycle from fire to outputs.
- No fire and not stalled: enable_ex <= 0. Data outputs hold their last values.
- FSM:
  - RUN: instr_ready = ~stall_in & ~hazard & reset.
    - stall_in=1: all outputs hold, including enable_ex.
    - hazard & instr_valid & ~stall_in: enable_ex <= 0 and go to BUBBLE.
  - BUBBLE: instr_ready=0 and enable_ex stays 0 for exactly one cycle, then return to RUN. The held instruction then issues with no hazard, because the bubble has cleared the prior MEM_READ.
    - stall_in=1 in BUBBLE: remain in BUBBLE.
- Priority: reset > stall_in > hazard > issue.
- Reset asserted mid-BUBBLE returns to RUN with all outputs zeroed.
- wb_en and a same-register read in the same cycle: bypass applies; the issued operand equals wb_data.

Decomposition:
- Shared package decode_pkg holds:
  - op_type codes (MEM_READ, MEM_WRITE, ARITH_LOGIC, SHIFT_REG) and opselect codes;
  - instruction field bit positions;
  - the state enum {RUN, BUBBLE};
  - a packed struct for the 7-bit control word.
- One sub-module, reg_file: 8x32, two asynchronous read ports with write bypass, one synchronous write port, r0 hardwired to 0.

Test Plan:
- Reset released, no instr_valid -> enable_ex=0, src1=src2=imm=0, control_in=0, instr_ready=1 once reset=1.
- Write r1=5 and r2=7 via wb, then issue ADD reg-reg (op 001, sel 000, imm_sel 0, rd 3, rs1 1, rs2 2) -> next cycle src1=5, src2=7, control_in=7'b0010000, enable_ex=1, dest_out=3.
- Immediate extension:
  - imm16=16'hFFF0 with op 001/sel 000 -> imm=32'hFFFFFFF0;
  - same imm16 with sel AND (100) -> imm=32'h0000FFF0.
- Load-use hazard: MEM_READ rd=4, then ADD rs1=4 held valid:
  - one cycle with enable_ex=0 and instr_ready=0;
  - ADD issues the following cycle;
  - the same case with rd=0 gives no bubble.
- stall_in=1 for 3 cycles mid-stream -> outputs and enable_ex frozen, instr_ready=0; resumes with no lost or duplicated instruction.
- Same-cycle wb_en to r5=32'hDEADBEEF while issuing an instruction reading rs1=5 -> src1=32'hDEADBEEF.
- Assert reset in BUBBLE -> all outputs 0 immediately; after release, state RUN and instr_ready=1.
